// File: rtl/mult_div_seq.sv
// Iterative signed multiply / restoring divide for the multi-cycle datapath.
// Optional MULT_DIV_EARLY_EXIT_EN: multiply stops once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for MultCtrl/DivCtrl
// MULT  | one shift-add step per cycle
// DIV   | one restoring step per cycle
// FIX   | apply recorded signs, register Hi/Lo
// DONE  | one-cycle done; HiLoWrite or DivZero
module mult_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             DivZero,
  output logic             HiLoWrite,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod, mcand, prod_neg;
  logic [WIDTH-1:0]   mplier, quo, rem, dvsr, quo_neg, rem_neg;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_fits;
  logic               sign_p, sign_q, sign_r, is_div, div_zero;
  logic               last_iter, mult_last;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v) + WIDTH'(1) : v;
  endfunction

  assign last_iter = (cnt == CNT_W'(WIDTH-1));

`ifdef MULT_DIV_EARLY_EXIT_EN
  assign mult_last = last_iter || (mplier[WIDTH-1:1] == '0);
`else
  assign mult_last = last_iter;
`endif

  // Remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvsr};
  assign div_fits  = (div_shift >= {1'b0, dvsr});

  assign prod_neg = (~prod) + (2*WIDTH)'(1);
  assign quo_neg  = (~quo) + WIDTH'(1);
  assign rem_neg  = (~rem) + WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    DivZero   = 1'b0;
    HiLoWrite = 1'b0;
    case (state)
      S_IDLE: begin
        if (MultCtrl)     state_nxt = S_MULT;
        else if (DivCtrl) state_nxt = (B == '0) ? S_DONE : S_DIV;
      end
      S_MULT: begin
        busy = 1'b1;
        if (mult_last) state_nxt = S_FIX;
      end
      S_DIV: begin
        busy = 1'b1;
        if (last_iter) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        DivZero   = div_zero;
        HiLoWrite = !div_zero;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      sign_p   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (MultCtrl) begin
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            prod     <= '0;
            mcand    <= {{WIDTH{1'b0}}, mag(A)};
            mplier   <= mag(B);
            sign_p   <= A[WIDTH-1] ^ B[WIDTH-1];
          end else if (DivCtrl) begin
            is_div   <= 1'b1;
            div_zero <= (B == '0);
            rem      <= '0;
            quo      <= mag(A);
            dvsr     <= mag(B);
            sign_q   <= A[WIDTH-1] ^ B[WIDTH-1];
            sign_r   <= A[WIDTH-1];
          end
        end
        S_MULT: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        S_DIV: begin
          rem <= div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], div_fits};
          cnt <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (is_div) begin
            Hi <= sign_r ? rem_neg : rem;
            Lo <= sign_q ? quo_neg : quo;
          end else begin
            {Hi, Lo} <= sign_p ? prod_neg : prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: expected Hi/Lo/DivZero/latency queued at start, checked on done.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MultCtrl = 1'b0;
  logic        DivCtrl = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, DivZero, HiLoWrite;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          start;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  mult_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .MultCtrl(MultCtrl), .DivCtrl(DivCtrl),
    .A(A), .B(B), .busy(busy), .done(done), .DivZero(DivZero),
    .HiLoWrite(HiLoWrite), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, "_hi"}, Hi, e.hi);
        check({e.tag, "_lo"}, Lo, e.lo);
        check({e.tag, "_divzero"}, DivZero, e.dz);
        check({e.tag, "_hilowrite"}, HiLoWrite, !e.dz);
        check({e.tag, "_latency"}, cyc - e.start + 1, e.lat);
      end
    end
  end

  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t e;
    bit   seen = 0;
    @(negedge clk);
    A = a; B = b; MultCtrl = m; DivCtrl = d;
    @(posedge clk); #1;
    e.tag = tag; e.hi = ehi; e.lo = elo; e.dz = edz;
    e.start = cyc; e.lat = edz ? 1 : 34;
    exp_q.push_back(e);
    MultCtrl = 0; DivCtrl = 0;
    A = $urandom; B = $urandom;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      check({tag, "_busy"}, busy, 1);
    end
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
      void'(exp_q.pop_back());
    end else begin
      check({tag, "_busy_at_done"}, busy, 0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 0);
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, b;
      int          sa, sb;
      longint      p;
      bit          is_mul;
      is_mul = $urandom_range(0, 1) == 1;
      do begin
        a = $urandom; b = $urandom;
        if (i % 3 == 0) b = b >>> 20;
      end while (!is_mul && (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)));
      sa = a; sb = b;
      if (is_mul) begin
        p = longint'(sa) * longint'(sb);
        run_op("rnd_mul", 1, 0, a, b, p[63:32], p[31:0], 0);
      end else begin
        run_op("rnd_div", 0, 1, a, b, 32'(sa % sb), 32'(sa / sb), 0);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_divzero", DivZero, 0);
    check("reset_hilowrite", HiLoWrite, 0);
    check("reset_hilo", {Hi, Lo}, 64'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_op("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("div_7_m2", 0, 1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_op("div_preload", 0, 1, 32'd5, 32'd2, 32'h1, 32'h2, 0);
    run_op("div_by_zero", 0, 1, 32'd5, 32'd0, 32'h1, 32'h2, 1);
    run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
    run_op("mul_min_m1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);

    // Abort a multiply with reset; nothing is queued, so any done here is flagged.
    @(negedge clk);
    A = 32'd9; B = 32'd9; MultCtrl = 1;
    @(posedge clk); #1 MultCtrl = 0;
    repeat (9) @(posedge clk);
    #1 DivCtrl = 1;
    @(posedge clk); #1 DivCtrl = 0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_divzero", DivZero, 0);
    check("abort_hilowrite", HiLoWrite, 0);
    check("abort_hilo", {Hi, Lo}, 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    run_op("mul_after_reset", 1, 0, 32'd3, 32'd4, 32'h0, 32'd12, 0);
    run_op("mul_div_both", 1, 1, 32'd6, 32'd3, 32'h0, 32'd18, 0);
    repeat (40) @(negedge clk);
    check("hilo_hold", {Hi, Lo}, {32'h0, 32'd18});

    run_random(8);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
